// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared frame geometry and feeder state encoding
package bnn_pkg;
  localparam int IMG_PIXELS = 784;
  localparam int PIX_W      = 32;
  localparam int ADDR_W     = 10;

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_WAIT   = 2'd3
  } feeder_state_t;
endpackage

// File: rtl/pixel_ram.sv
// rtl/pixel_ram.sv - simple dual-port frame buffer, one write port, one registered read port
module pixel_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 784,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // No reset on purpose so the array and read register map onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/image_feeder.sv
// rtl/image_feeder.sv - collects one frame from the host and replays it to the CNN on demand
module image_feeder #(
  parameter int PIX_W  = bnn_pkg::PIX_W,
  parameter int N_PIX  = bnn_pkg::IMG_PIXELS,
  parameter int ADDR_W = bnn_pkg::ADDR_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic [PIX_W-1:0] wr_data,
  output logic             wr_ready,
  output logic             start,
  output logic [PIX_W-1:0] din,
  input  logic             din_ready,
  input  logic             conv1_done,
  input  logic             cnn_done,
  output logic             frame_sent,
  output logic             err
);
  import bnn_pkg::*;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_PIX - 1);

  feeder_state_t    state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PIX_W-1:0]  din_q, din_d;
  logic              start_q, start_d;
  logic              frame_sent_q, frame_sent_d;
  logic              err_q, err_d;
  logic              wr_ready_q, wr_ready_d;
  logic              c1_seen_q, c1_seen_d;
  logic              ram_we;
  logic [PIX_W-1:0]  ram_rdata;

  // Reading at the next pointer keeps ram_rdata == buf[rd_ptr_q], so every
  // din_ready edge can take a pixel without a bubble.
  pixel_ram #(
    .WIDTH (PIX_W),
    .DEPTH (N_PIX),
    .AW    (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .raddr (rd_ptr_d),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    din_d        = din_q;
    start_d      = start_q;
    frame_sent_d = 1'b0;
    err_d        = err_q;
    c1_seen_d    = c1_seen_q;
    ram_we       = 1'b0;

    if (wr_en && state_q != S_LOAD) err_d = 1'b1;

    case (state_q)
      S_LOAD: begin
        start_d = 1'b0;
        if (wr_en) begin
          ram_we = 1'b1;
          if (wr_ptr_q == LAST) begin
            wr_ptr_d  = '0;
            state_d   = S_STREAM;
            start_d   = 1'b1;
            c1_seen_d = 1'b0;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end
      S_STREAM: begin
        // An early conv1_done drops start now but the frame still finishes.
        if (conv1_done) begin
          start_d   = 1'b0;
          c1_seen_d = 1'b1;
        end
        if (din_ready) begin
          din_d = ram_rdata;
          if (rd_ptr_q == LAST) begin
            frame_sent_d = 1'b1;
            state_d      = S_DRAIN;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (din_ready) err_d = 1'b1;
        if (conv1_done || c1_seen_q) begin
          start_d = 1'b0;
          state_d = S_WAIT;
        end
      end
      default: begin
        start_d = 1'b0;
        if (din_ready) err_d = 1'b1;
        if (cnn_done) begin
          state_d  = S_LOAD;
          rd_ptr_d = '0;
        end
      end
    endcase

    wr_ready_d = (state_d == S_LOAD);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_LOAD;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      din_q        <= '0;
      start_q      <= 1'b0;
      frame_sent_q <= 1'b0;
      err_q        <= 1'b0;
      wr_ready_q   <= 1'b0;
      c1_seen_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      din_q        <= din_d;
      start_q      <= start_d;
      frame_sent_q <= frame_sent_d;
      err_q        <= err_d;
      wr_ready_q   <= wr_ready_d;
      c1_seen_q    <= c1_seen_d;
    end
  end

  assign wr_ready   = wr_ready_q;
  assign start      = start_q;
  assign din        = din_q;
  assign frame_sent = frame_sent_q;
  assign err        = err_q;
endmodule

// File: tb/tb_image_feeder.sv
// tb/tb_image_feeder.sv - self-checking bench for image_feeder
module tb_image_feeder;
  localparam int NP = 784;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        start;
  logic [31:0] din;
  logic        din_ready;
  logic        conv1_done;
  logic        cnn_done;
  logic        frame_sent;
  logic        err;

  image_feeder dut (
    .clk        (clk),
    .rstn       (rstn),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .start      (start),
    .din        (din),
    .din_ready  (din_ready),
    .conv1_done (conv1_done),
    .cnn_done   (cnn_done),
    .frame_sent (frame_sent),
    .err        (err)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] frame [NP];
  int          idx_sent;
  logic [31:0] exp_din;
  logic        exp_err;
  logic        exp_start;
  logic [31:0] prev_last;

  typedef struct {
    logic dr;
    logic wr;
    int   exp_idx;
    logic exp_err;
  } vec_t;
  vec_t vecs [9];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_frame;
    for (int i = 0; i < NP; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        wr_en = 1'b0;
        tick();
      end
      wr_en   = 1'b1;
      wr_data = frame[i];
      tick();
      check("load_wr_ready", {31'd0, wr_ready}, (i < NP - 1) ? 32'd1 : 32'd0);
    end
    wr_en = 1'b0;
    exp_start = 1'b1;
    check("load_start", {31'd0, start}, 32'd1);
  endtask

  // Pixel i must appear on din after the (i+1)-th sampled request.
  task automatic stream_run(input int rnd, input int stop_at, input int c1_at);
    int cyc = 0;
    logic dr;
    logic fs;
    while (idx_sent < stop_at && cyc < 10000) begin
      dr = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      din_ready  = dr;
      conv1_done = (cyc == c1_at);
      tick();
      fs = 1'b0;
      if (dr) begin
        exp_din = frame[idx_sent];
        fs = (idx_sent == NP - 1);
        idx_sent++;
      end
      if (cyc == c1_at) exp_start = 1'b0;
      check("stream_din", din, exp_din);
      check("stream_frame_sent", {31'd0, frame_sent}, {31'd0, fs});
      check("stream_start", {31'd0, start}, {31'd0, exp_start});
      check("stream_err", {31'd0, err}, {31'd0, exp_err});
      check("stream_wr_ready", {31'd0, wr_ready}, 32'd0);
      cyc++;
    end
    din_ready  = 1'b0;
    conv1_done = 1'b0;
    if (idx_sent < stop_at) check("stream_timeout", idx_sent, stop_at);
  endtask

  task automatic finish_frame;
    check("wait_start", {31'd0, start}, 32'd0);
    cnn_done = 1'b1;
    tick();
    cnn_done = 1'b0;
    check("cnn_done_wr_ready", {31'd0, wr_ready}, 32'd1);
    idx_sent = 0;
  endtask

  initial begin
    rstn = 1'b0; wr_en = 1'b0; wr_data = '0; din_ready = 1'b0;
    conv1_done = 1'b0; cnn_done = 1'b0;
    exp_err = 1'b0; exp_din = '0; exp_start = 1'b0; idx_sent = 0;
    #12;
    check("rst_din", din, 32'd0);
    check("rst_start", {31'd0, start}, 32'd0);
    check("rst_frame_sent", {31'd0, frame_sent}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    @(posedge clk); #1; rstn = 1'b1;
    tick();
    check("post_rst_wr_ready", {31'd0, wr_ready}, 32'd1);

    // Frame A: value = index, continuous din_ready.
    for (int i = 0; i < NP; i++) frame[i] = i;
    load_frame();
    stream_run(0, NP, -1);
    check("a_last_din", din, 32'd783);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("drain_start_held", {31'd0, start}, 32'd1);
    end
    conv1_done = 1'b1;
    tick();
    conv1_done = 1'b0;
    check("conv1_start_drop", {31'd0, start}, 32'd0);
    tick();
    check("a_err_clear", {31'd0, err}, 32'd0);
    finish_frame();

    // Frame B: random pixels with a negative first pixel, table-driven start.
    prev_last = frame[NP-1];
    for (int i = 0; i < NP; i++) frame[i] = $urandom;
    frame[0] = 32'hFFFFFFFB;
    load_frame();
    vecs[0] = '{1'b0, 1'b0, -1, 1'b0};
    vecs[1] = '{1'b1, 1'b0,  0, 1'b0};
    vecs[2] = '{1'b0, 1'b0,  0, 1'b0};
    vecs[3] = '{1'b0, 1'b0,  0, 1'b0};
    vecs[4] = '{1'b1, 1'b0,  1, 1'b0};
    vecs[5] = '{1'b1, 1'b0,  2, 1'b0};
    vecs[6] = '{1'b0, 1'b1,  2, 1'b1};
    vecs[7] = '{1'b1, 1'b0,  3, 1'b1};
    vecs[8] = '{1'b1, 1'b0,  4, 1'b1};
    for (int v = 0; v < 9; v++) begin
      din_ready = vecs[v].dr;
      wr_en     = vecs[v].wr;
      wr_data   = 32'hDEADBEEF;
      tick();
      check("vec_din", din, (vecs[v].exp_idx < 0) ? prev_last : frame[vecs[v].exp_idx]);
      check("vec_err", {31'd0, err}, {31'd0, vecs[v].exp_err});
      if (v == 1) check("neg_pixel", din, 32'hFFFFFFFB);
    end
    din_ready = 1'b0; wr_en = 1'b0;
    idx_sent = 5; exp_din = frame[4]; exp_err = 1'b1;
    stream_run(1, NP, $urandom_range(20, 600));
    din_ready = 1'b1;
    tick();
    din_ready = 1'b0;
    check("exhausted_din", din, frame[NP-1]);
    check("exhausted_err", {31'd0, err}, 32'd1);
    check("exhausted_frame_sent", {31'd0, frame_sent}, 32'd0);
    tick();
    finish_frame();

    // Frame C: asynchronous reset in the middle of streaming.
    for (int i = 0; i < NP; i++) frame[i] = $urandom;
    load_frame();
    stream_run(1, 400, -1);
    #3 rstn = 1'b0;
    #1;
    check("async_din", din, 32'd0);
    check("async_start", {31'd0, start}, 32'd0);
    check("async_frame_sent", {31'd0, frame_sent}, 32'd0);
    check("async_err", {31'd0, err}, 32'd0);
    check("async_wr_ready", {31'd0, wr_ready}, 32'd0);
    @(posedge clk); #1; rstn = 1'b1;
    tick();
    check("rerst_wr_ready", {31'd0, wr_ready}, 32'd1);
    exp_err = 1'b0; exp_din = '0; idx_sent = 0;

    // Frame D: full frame after reset must start from index 0.
    for (int i = 0; i < NP; i++) frame[i] = $urandom;
    load_frame();
    stream_run(1, NP, -1);
    conv1_done = 1'b1;
    tick();
    conv1_done = 1'b0;
    check("d_conv1_start_drop", {31'd0, start}, 32'd0);
    tick();
    finish_frame();
    check("d_err_clear", {31'd0, err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
